// File: rtl/bam_seq_mult_ctrl.sv
// bam_seq_mult_ctrl: sequential unsigned multiplier, one Bam_cell row reused over WIDTH cycles
`timescale 1ns/1ps
module bam_cell (
  input  logic a,
  input  logic b,
  input  logic pre_out,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  logic pp;
  assign pp = a & b;
  assign sum = pp ^ pre_out ^ carry_in;
  assign carry_out = (pp & pre_out) | (carry_in & (pp ^ pre_out));
endmodule

module bam_seq_mult_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg, sum;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] carry;
  logic a_bit;
  assign a_bit = a_reg[cnt];
  assign carry[0] = 1'b0;
  genvar j;
  for (j = 0; j < WIDTH; j++) begin : g_cell
    bam_cell u_cell (
      .a(a_bit),
      .b(b_reg[j]),
      .pre_out(acc[WIDTH+j]),
      .carry_in(carry[j]),
      .sum(sum[j]),
      .carry_out(carry[j+1])
    );
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign P = out_valid ? acc : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? CALC : IDLE) :
               state == CALC ? (cnt == LAST ? DONE : CALC) :
               state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // top carry lands in acc[2W-1] so the full 2W-bit product is kept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else if (state == IDLE && in_valid) begin
      a_reg <= A;
      b_reg <= B;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= {carry[WIDTH], sum, acc[WIDTH-1:1]};
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_bam_seq_mult_ctrl.sv
// tb_bam_seq_mult_ctrl: directed and randomised checks of the sequential multiplier controller
`timescale 1ns/1ps
module tb_bam_seq_mult_ctrl;
  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, in_ready, out_valid, busy;
  logic [7:0] A, B;
  logic [15:0] P;
  int checks = 0;
  int errors = 0;

  bam_seq_mult_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (P !== 16'h0) begin errors++; $display("FAIL reset_p got %h exp 0000", P); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_op(8'd13, 8'd11, lat);
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    checks++; if (P !== 16'h008F) begin errors++; $display("FAIL basic_p got %h exp 008f", P); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got rdy=%b vld=%b busy=%b exp 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_corners();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [15:0] ep [3];
    int lat;
    av[0] = 8'hFF; bv[0] = 8'hFF; ep[0] = 16'hFE01;
    av[1] = 8'h00; bv[1] = 8'h5A; ep[1] = 16'h0000;
    av[2] = 8'h80; bv[2] = 8'h80; ep[2] = 16'h4000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL corner%0d_latency got %0d exp 8", i, lat); end
      checks++; if (P !== ep[i]) begin errors++; $display("FAIL corner%0d_p got %h exp %h", i, P, ep[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_op(8'd7, 8'd9, lat);
    checks++; if (P !== 16'h003F || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_first got p=%h vld=%b exp 003f 1", P, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (P !== 16'h003F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got p=%h vld=%b rdy=%b exp 003f 1 0", i, P, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [15:0] ep [3];
    int idx = 0;
    int got = 0;
    int last_acc = -1;
    logic rdy;
    av[0] = 8'd3;   bv[0] = 8'd5;   ep[0] = 16'd15;
    av[1] = 8'd200; bv[1] = 8'd201; ep[1] = 16'h9D08;
    av[2] = 8'd255; bv[2] = 8'd1;   ep[2] = 16'd255;
    out_ready = 1'b1;
    A = av[0]; B = bv[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid) begin
        if (idx > 0) begin
          checks++; if (cyc - last_acc != 10) begin
            errors++; $display("FAIL b2b_spacing%0d got %0d exp 10", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx < 3) begin A = av[idx]; B = bv[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        checks++; if (P !== ep[got]) begin errors++; $display("FAIL b2b_p%0d got %h exp %h", got, P, ep[got]); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    A = 8'hAA; B = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || P !== 16'h0) begin
      errors++; $display("FAIL mid_reset got vld=%b busy=%b p=%h exp 0 0 0000", out_valid, busy, P);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(8'd2, 8'd3, lat);
    checks++; if (P !== 16'd6 || lat != 8) begin errors++; $display("FAIL mid_after got p=%h lat=%0d exp 0006 8", P, lat); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || P !== 16'h0) begin
      errors++; $display("FAIL done_reset got vld=%b p=%h exp 0 0000", out_valid, P);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_reset_rdy got %b exp 1", in_ready); end
  endtask

  task automatic test_random();
    logic [15:0] q [$];
    logic [15:0] e, pv;
    logic rdy, vld, ov, ordy;
    int sent = 0;
    int got = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
      rdy = in_ready; vld = in_valid; ov = out_valid; ordy = out_ready; pv = P;
      @(posedge clk); #1;
      if (rdy && vld) begin
        q.push_back({8'h0, A} * {8'h0, B});
        sent++;
      end
      if (ov && ordy) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra got %h exp none", pv);
        end else begin
          e = q.pop_front();
          if (pv !== e) begin errors++; $display("FAIL rand_p%0d got %h exp %h", got, pv, e); end
        end
        got++;
      end else if (ov) begin
        checks++; if (out_valid !== 1'b1 || P !== pv) begin
          errors++; $display("FAIL rand_hold got vld=%b p=%h exp 1 %h", out_valid, P, pv);
        end
      end
      in_valid = sent < 1000 && $urandom_range(0, 2) != 0;
      A = 8'($urandom);
      B = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    checks++; if (got != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rand_count got %0d left %0d exp 1000 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
